// File: rtl/pads_pkg.sv
// pads_pkg: shared state encoding for the pad-ring power sequencer
package pads_pkg;
    localparam int ST_W = 2;
    typedef enum logic [ST_W-1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } pwr_st_e;
endpackage

// File: rtl/pads_pwr_step_cnt.sv
// pads_pwr_step_cnt: loadable down-counter timing the settle gap between group steps
module pads_pwr_step_cnt #(
    parameter int DLY_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ld_i,
    input  logic [DLY_W-1:0] ld_val_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [DLY_W-1:0] cnt_q;
    // load has priority; decrement saturates at zero so the count never wraps
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else if (ld_i) cnt_q <= ld_val_i;
        else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/pads_pwr_seq.sv
// pads_pwr_seq: enables pad supply groups one at a time with a settle gap, reverse order on power-down
module pads_pwr_seq
    import pads_pkg::*;
#(
    parameter int N_GRP = 4,
    parameter int DLY_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [DLY_W-1:0] dly_i,
    output logic [N_GRP-1:0] grp_en_o,
    output logic             iso_o,
    output logic             pwr_ok_o,
    output logic             busy_o,
    output logic [ST_W-1:0]  state_o
);
    localparam int IDX_W = N_GRP > 1 ? $clog2(N_GRP) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_GRP - 1);
    pwr_st_e          state_q;
    logic [IDX_W-1:0] idx_q;
    logic [DLY_W-1:0] d_q;
    logic [N_GRP-1:0] grp_q;
    logic             iso_q, pwr_ok_q, busy_q;
    logic             smp, ld, dec, zero;
    logic [DLY_W-1:0] ld_val;
    // counter control: a fresh dly_i is taken only when a sequence starts or reverses
    always_comb begin
        smp    = (state_q == ST_OFF && en_i) || ((state_q == ST_UP || state_q == ST_ON) && !en_i);
        ld     = smp || (zero && ((state_q == ST_UP && en_i && idx_q != IDX_LAST) ||
                                  (state_q == ST_DOWN && idx_q != '0)));
        ld_val = smp ? dly_i : d_q;
        dec    = !zero && ((state_q == ST_UP && en_i) || state_q == ST_DOWN);
    end
    pads_pwr_step_cnt #(.DLY_W(DLY_W)) u_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .ld_i    (ld),
        .ld_val_i(ld_val),
        .dec_i   (dec),
        .zero_o  (zero)
    );
    // sequencer FSM; grp_q grows/shrinks as a thermometer so shifting sets/clears bit idx
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_OFF;
            idx_q    <= '0;
            d_q      <= '0;
            grp_q    <= '0;
            iso_q    <= 1'b1;
            pwr_ok_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_OFF: if (en_i) begin
                    state_q <= ST_UP;
                    grp_q   <= N_GRP'(1);
                    idx_q   <= '0;
                    d_q     <= dly_i;
                    busy_q  <= 1'b1;
                end
                ST_UP: if (!en_i) begin
                    state_q <= ST_DOWN;
                    d_q     <= dly_i;
                end else if (zero) begin
                    if (idx_q != IDX_LAST) begin
                        idx_q <= idx_q + 1'b1;
                        grp_q <= (grp_q << 1) | N_GRP'(1);
                    end else begin
                        state_q  <= ST_ON;
                        pwr_ok_q <= 1'b1;
                        iso_q    <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
                ST_ON: if (!en_i) begin
                    state_q  <= ST_DOWN;
                    d_q      <= dly_i;
                    pwr_ok_q <= 1'b0;
                    iso_q    <= 1'b1;
                    busy_q   <= 1'b1;
                end
                ST_DOWN: if (zero) begin
                    grp_q <= grp_q >> 1;
                    if (idx_q == '0) begin
                        state_q <= ST_OFF;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
            endcase
        end
    end
    assign grp_en_o = grp_q;
    assign iso_o    = iso_q;
    assign pwr_ok_o = pwr_ok_q;
    assign busy_o   = busy_q;
    assign state_o  = state_q;
endmodule

// File: tb/tb_pads_pwr_seq.sv
// tb_pads_pwr_seq: timeline model of the pad sequencer checked every cycle, plus directed literal checks
module tb_pads_pwr_seq;
    localparam int N = 4;
    logic       clk = 0, rst = 0, en = 0, en1 = 0;
    logic [7:0] dly = 0, dly1 = 0;
    logic [3:0] grp;
    logic       iso, pok, busy;
    logic [1:0] st;
    logic [0:0] grp1;
    logic       iso1, pok1, busy1;
    logic [1:0] st1;
    int         checks = 0, failures = 0;
    bit         armed = 0;
    int         m_mode = 0, m_t = 0, m_d = 0, m_n0 = 0;

    pads_pwr_seq #(.N_GRP(N), .DLY_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .dly_i(dly),
        .grp_en_o(grp), .iso_o(iso), .pwr_ok_o(pok), .busy_o(busy), .state_o(st)
    );
    pads_pwr_seq #(.N_GRP(1), .DLY_W(8)) dut1 (
        .clk_i(clk), .rst_i(rst), .en_i(en1), .dly_i(dly1),
        .grp_en_o(grp1), .iso_o(iso1), .pwr_ok_o(pok1), .busy_o(busy1), .state_o(st1)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic int up_cnt(int t, int d);
        return (t / (d + 1) + 1 > N) ? N : t / (d + 1) + 1;
    endfunction

    function automatic int groups();
        case (m_mode)
            1: return up_cnt(m_t, m_d);
            2: return N;
            3: return m_n0 - m_t / (m_d + 1);
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] exp_mask();
        return 4'((1 << groups()) - 1);
    endfunction

    // mode: 0 off, 1 ramping up, 2 on, 3 ramping down; m_t = edges since the phase began
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0;
            m_t = 0;
        end else begin
            case (m_mode)
                0: if (en) begin m_mode = 1; m_t = 0; m_d = int'(dly); end
                1: if (!en) begin
                    m_n0 = up_cnt(m_t, m_d);
                    m_mode = 3; m_t = 0; m_d = int'(dly);
                end else begin
                    m_t++;
                    if (m_t >= N * (m_d + 1)) m_mode = 2;
                end
                2: if (!en) begin m_mode = 3; m_t = 0; m_d = int'(dly); m_n0 = N; end
                default: begin
                    m_t++;
                    if (m_n0 - m_t / (m_d + 1) <= 0) m_mode = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (armed && !rst)
            chk("cycle", {23'd0, st, grp, iso, pok, busy},
                {23'd0, 2'(m_mode), exp_mask(), m_mode != 2, m_mode == 2, m_mode == 1 || m_mode == 3});
    end

    task automatic go(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lit(string nm, logic [3:0] g, logic [1:0] s);
        chk({nm, "_grp"}, grp, g);
        chk({nm, "_st"}, st, s);
        chk({nm, "_model"}, exp_mask(), g);
    endtask

    initial begin
        #1 rst = 1;
        #1;
        chk("rst_grp", grp, 4'b0000);
        chk("rst_iso", iso, 1);
        chk("rst_pok", pok, 0);
        chk("rst_busy", busy, 0);
        chk("rst_st", st, 0);
        chk("rst_grp1", grp1, 0);
        #1 rst = 0;
        armed = 1;
        go(1);
        dly = 3; en = 1;
        go(1); lit("up_e1", 4'b0001, 1);
        go(4); lit("up_e5", 4'b0011, 1);
        go(4); lit("up_e9", 4'b0111, 1);
        go(4); lit("up_e13", 4'b1111, 1);
        go(4); lit("up_e17", 4'b1111, 2);
        chk("up_e17_pok", pok, 1);
        chk("up_e17_iso", iso, 0);
        go(3);
        en = 0;
        go(1); lit("dn_e1", 4'b1111, 3);
        chk("dn_e1_iso", iso, 1);
        chk("dn_e1_pok", pok, 0);
        go(4); lit("dn_e5", 4'b0111, 3);
        go(4); lit("dn_e9", 4'b0011, 3);
        go(4); lit("dn_e13", 4'b0001, 3);
        go(4); lit("dn_e17", 4'b0000, 0);
        en = 1;
        go(5); lit("ab_up", 4'b0011, 1);
        en = 0;
        go(1); lit("ab_dn", 4'b0011, 3);
        go(2); en = 1;
        go(2); lit("ab_4", 4'b0001, 3);
        go(4); lit("ab_8", 4'b0000, 0);
        go(1); lit("ab_restart", 4'b0001, 1);
        en = 0;
        go(1); lit("ab2_dn", 4'b0001, 3);
        go(4); lit("ab2_off", 4'b0000, 0);
        dly = 0; en = 1;
        go(1); lit("d0_e1", 4'b0001, 1);
        dly = 9;
        go(1); lit("d0_e2", 4'b0011, 1);
        go(1); lit("d0_e3", 4'b0111, 1);
        go(1); lit("d0_e4", 4'b1111, 1);
        go(1); lit("d0_e5", 4'b1111, 2);
        chk("d0_pok", pok, 1);
        dly = 0; en = 0;
        go(1); lit("d0_dn", 4'b1111, 3);
        go(4); lit("d0_off", 4'b0000, 0);
        dly = 3; en = 1;
        go(9); lit("mid_up", 4'b0111, 1);
        rst = 1;
        #1;
        chk("mid_rst_grp", grp, 4'b0000);
        chk("mid_rst_iso", iso, 1);
        chk("mid_rst_st", st, 0);
        chk("mid_rst_busy", busy, 0);
        en = 0;
        #1 rst = 0;
        dly1 = 2; en1 = 1;
        go(1);
        chk("n1_e1_grp", grp1, 1);
        chk("n1_e1_st", st1, 1);
        go(2);
        chk("n1_e3_st", st1, 1);
        go(1);
        chk("n1_e4_st", st1, 2);
        chk("n1_e4_pok", pok1, 1);
        chk("n1_e4_iso", iso1, 0);
        en1 = 0;
        go(1);
        chk("n1_dn_st", st1, 3);
        chk("n1_dn_iso", iso1, 1);
        chk("n1_dn_grp", grp1, 1);
        go(3);
        chk("n1_off_grp", grp1, 0);
        chk("n1_off_st", st1, 0);
        go(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
